// File: rtl/id_imm_mc_pkg.sv
// id_imm_mc_pkg: shared definitions for the multi-cycle immediate decode
// path. Holds the FSM state encoding, the I-type opcode constants and small
// opcode classification helpers.
package id_imm_mc_pkg;

  // FSM states of the immediate decode path
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_READ  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Supported I-type ALU opcodes (all live in 6'b001xxx)
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // True for the eight immediate ALU ops handled by this block
  function automatic logic op_supported(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

  // True for supported ops that need the rs register value (all but LUI)
  function automatic logic op_needs_rs(input logic [5:0] op);
    return op_supported(op) && (op != OP_LUI);
  endfunction

endpackage

// File: rtl/id_imm_mc_scoreboard.sv
// id_imm_scoreboard: one pending-write bit per architectural register.
// A set and a clear of the same bit in one cycle leaves the bit set, and
// register 0 is never marked pending. Used only when ID_IMM_SCOREBOARD_EN
// is defined.
module id_imm_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_set_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_set_addr,
  input  logic                      i_clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_clr_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_lookup_addr,
  output logic                      o_pending
);

  localparam int NREGS = 1 << REG_ADDR_WIDTH;

  logic [NREGS-1:0] r_bits;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;

  // Decode set/clear requests into one-hot masks; register 0 never sets
  always_comb begin
    w_set_mask = {NREGS{1'b0}};
    w_clr_mask = {NREGS{1'b0}};
    if (i_set_en && (i_set_addr != {REG_ADDR_WIDTH{1'b0}})) begin
      w_set_mask[i_set_addr] = 1'b1;
    end else begin
      w_set_mask = {NREGS{1'b0}};
    end
    if (i_clr_en) begin
      w_clr_mask[i_clr_addr] = 1'b1;
    end else begin
      w_clr_mask = {NREGS{1'b0}};
    end
  end

  // Pending bits: clear first, then set, so a same-cycle set wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bits <= {NREGS{1'b0}};
    end else begin
      r_bits <= (r_bits & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_pending = r_bits[i_lookup_addr];

endmodule

// File: rtl/id_imm_mc.sv
// id_imm_mc: multi-cycle, handshaked immediate decode for I-type ALU ops.
// Accepts an instruction, fetches rs through a variable-latency read port,
// and holds operands/write-back info for EX until it is accepted.
// Optional feature macro: ID_IMM_SCOREBOARD_EN (pending-write scoreboard
// that stalls rs reads hitting an outstanding write).
module id_imm_mc
  import id_imm_mc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  output logic                      inst_immediate,
  output logic                      reg_read_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic                      reg_read_valid,
  input  logic [DATA_WIDTH-1:0]     reg_read_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                out_op,
  output logic [DATA_WIDTH-1:0]     operand_1,
  output logic [DATA_WIDTH-1:0]     operand_2,
  output logic                      write_reg_en,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [REG_ADDR_WIDTH-1:0] r_rs;
  logic [5:0]                r_out_op;
  logic [DATA_WIDTH-1:0]     r_operand_1;
  logic [DATA_WIDTH-1:0]     r_operand_2;
  logic                      r_write_reg_en;
  logic [REG_ADDR_WIDTH-1:0] r_write_reg_addr;

  logic [5:0]                w_op;
  logic [15:0]               w_imm;
  logic [31:0]               w_lui32;
  logic [REG_ADDR_WIDTH-1:0] w_rs_in;
  logic [REG_ADDR_WIDTH-1:0] w_rt_in;
  logic [DATA_WIDTH-1:0]     w_imm_ext;
  logic                      w_accept;
  logic                      w_read_done;
  logic                      w_pending;

  assign w_op     = inst[31:26];
  assign w_imm    = inst[15:0];
  assign w_lui32  = {inst[15:0], 16'h0000};
  assign w_rs_in  = REG_ADDR_WIDTH'(inst[25:21]);
  assign w_rt_in  = REG_ADDR_WIDTH'(inst[20:16]);

  assign inst_immediate = op_supported(w_op);

  // Flush outranks both handshakes, so neither an accept nor a read completes
  assign w_accept    = (r_state == S_IDLE) && in_valid && !flush;
  assign w_read_done = (r_state == S_READ) && reg_read_valid && !flush;

`ifdef ID_IMM_SCOREBOARD_EN
  logic                      w_out_hs;
  logic [REG_ADDR_WIDTH-1:0] w_lookup_addr;

  assign w_out_hs      = (r_state == S_OUT) && out_ready && !flush;
  // In IDLE the incoming rs is checked; while stalled the captured rs is
  assign w_lookup_addr = (r_state == S_IDLE) ? w_rs_in : r_rs;

  id_imm_scoreboard #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_set_en     (w_out_hs && r_write_reg_en),
    .i_set_addr   (r_write_reg_addr),
    .i_clr_en     (wb_en),
    .i_clr_addr   (wb_addr),
    .i_lookup_addr(w_lookup_addr),
    .o_pending    (w_pending)
  );
`else
  logic w_unused_wb;

  assign w_pending   = 1'b0;
  assign w_unused_wb = ^{wb_en, wb_addr};
`endif

  // Immediate extension by opcode class; unsupported ops give zero
  always_comb begin
    w_imm_ext = {DATA_WIDTH{1'b0}};
    case (w_op)
      OP_ANDI, OP_ORI, OP_XORI:            w_imm_ext = DATA_WIDTH'(w_imm);
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: w_imm_ext = DATA_WIDTH'($signed(w_imm));
      OP_LUI:                              w_imm_ext = DATA_WIDTH'($signed(w_lui32));
      default:                             w_imm_ext = {DATA_WIDTH{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in_valid) begin
            w_next_state = S_IDLE;
          end else if (!op_needs_rs(w_op)) begin
            w_next_state = S_OUT;
          end else if (w_pending && (w_rs_in != {REG_ADDR_WIDTH{1'b0}})) begin
            w_next_state = S_STALL;
          end else begin
            w_next_state = S_READ;
          end
        end
        S_STALL: w_next_state = w_pending ? S_STALL : S_READ;
        S_READ:  w_next_state = reg_read_valid ? S_OUT : S_READ;
        S_OUT:   w_next_state = out_ready ? S_IDLE : S_OUT;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the registered state; in_ready is low during reset
  always_comb begin
    in_ready    = (r_state == S_IDLE) && !rst;
    reg_read_en = (r_state == S_READ);
    out_valid   = (r_state == S_OUT);
  end

  // Datapath: capture the instruction on accept and rs data when the read lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs             <= {REG_ADDR_WIDTH{1'b0}};
      r_out_op         <= 6'd0;
      r_operand_1      <= {DATA_WIDTH{1'b0}};
      r_operand_2      <= {DATA_WIDTH{1'b0}};
      r_write_reg_en   <= 1'b0;
      r_write_reg_addr <= {REG_ADDR_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_rs        <= w_rs_in;
      r_out_op    <= w_op;
      r_operand_1 <= {DATA_WIDTH{1'b0}};
      if (op_supported(w_op)) begin
        r_operand_2      <= w_imm_ext;
        r_write_reg_en   <= 1'b1;
        r_write_reg_addr <= w_rt_in;
      end else begin
        r_operand_2      <= {DATA_WIDTH{1'b0}};
        r_write_reg_en   <= 1'b0;
        r_write_reg_addr <= {REG_ADDR_WIDTH{1'b0}};
      end
    end else if (w_read_done) begin
      r_operand_1 <= reg_read_data;
    end
  end

  assign reg_addr       = r_rs;
  assign out_op         = r_out_op;
  assign operand_1      = r_operand_1;
  assign operand_2      = r_operand_2;
  assign write_reg_en   = r_write_reg_en;
  assign write_reg_addr = r_write_reg_addr;

endmodule
